// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron evaluation sequencer.
// Holds the FSM encoding and the product clamp used before accumulation.
package neuron_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] SAT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    BIAS,
    DONE
  } state_t;

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] val;
  } prod_t;

  // A full-width product that does not fit in DATA_W bits clamps to SAT_MAX.
  function automatic prod_t sat_prod(input logic [2*DATA_W-1:0] p);
    prod_t r;
    r.sat = |p[2*DATA_W-1:DATA_W];
    r.val = r.sat ? SAT_MAX : p[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/neuron_seq_ctrl_adder.sv
// Plain DATA_W-bit ripple adder with carry out; the single shared adder of the datapath.
// Purely combinational, no handshake.
module neuron_seq_ctrl_adder
  import neuron_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Sequences one neuron evaluation: accumulate N saturated x*w products, add bias, threshold.
// Result appears N_INPUTS+2 cycles after start with in_valid held; in/out use valid/ready.
module neuron_seq_ctrl
  import neuron_pkg::*;
#(
  parameter int                N_INPUTS = 4,
  parameter logic [DATA_W-1:0] THRESH   = 8'd128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              fire,
  output logic              overflow
);

  localparam logic [7:0] LAST_BEAT = 8'(N_INPUTS - 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_bias;
  logic [7:0]          r_count;
  logic                r_overflow;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_result;
  logic                r_fire;

  logic [2*DATA_W-1:0] w_prod;
  prod_t               w_prod_sat;
  logic [DATA_W-1:0]   w_add_b;
  logic [DATA_W-1:0]   w_sum;
  logic                w_carry;
  logic [DATA_W-1:0]   w_sat_sum;
  logic                w_beat;

  assign w_prod     = 16'(x_in) * 16'(w_in);
  assign w_prod_sat = sat_prod(w_prod);
  // Operand B of the shared adder: clamped product while accumulating, bias in the bias step.
  assign w_add_b    = (r_state == BIAS) ? r_bias : w_prod_sat.val;
  assign w_sat_sum  = w_carry ? SAT_MAX : w_sum;
  assign w_beat     = in_valid && r_in_ready;

  neuron_seq_ctrl_adder u_adder (
    .i_a     (r_acc),
    .i_b     (w_add_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_bias      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_fire      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bias     <= bias;
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc      <= w_sat_sum;
            r_overflow <= r_overflow | w_prod_sat.sat | w_carry;
            r_count    <= r_count + 8'd1;
            if (r_count == LAST_BEAT) begin
              r_in_ready <= 1'b0;
              r_state    <= BIAS;
            end
          end
        end
        BIAS: begin
          // Result and fire are registered here so they are already valid with out_valid.
          r_acc       <= w_sat_sum;
          r_overflow  <= r_overflow | w_carry;
          r_result    <= w_sat_sum;
          r_fire      <= (w_sat_sum >= THRESH);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign fire      = r_fire;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Self-checking bench for neuron_seq_ctrl: directed scenarios plus randomized runs
// compared against an arithmetic reference model.
module tb_neuron_seq_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] bias;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x_in;
  logic [7:0] w_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       fire;
  logic       overflow;

  neuron_seq_ctrl #(.N_INPUTS(N), .THRESH(8'd128)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .fire      (fire),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] vx[N];
  logic [7:0] vw[N];

  int         got_lat;
  logic [7:0] got_res;
  logic       got_fire;
  logic       got_ov;
  logic       got_to;
  int         got_unstable;
  logic       got_exit;
  logic       got_busy_at;

  // Reference: saturating sum of clamped products, then saturating bias add.
  task automatic ref_model(input logic [7:0] b, output logic [7:0] r, output logic ov);
    int acc;
    int p;
    acc = 0;
    ov  = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = int'(vx[i]) * int'(vw[i]);
      if (p > 255) begin p = 255; ov = 1'b1; end
      acc = acc + p;
      if (acc > 255) begin acc = 255; ov = 1'b1; end
    end
    acc = acc + int'(b);
    if (acc > 255) begin acc = 255; ov = 1'b1; end
    r = 8'(acc);
  endtask

  task automatic set_nominal();
    for (int i = 0; i < N; i++) begin
      vx[i] = 8'(i + 1);
      vw[i] = 8'd2;
    end
  endtask

  // Drives one full evaluation from IDLE through the output handshake.
  task automatic run_eval(input logic [7:0] b, input int gap, input bit rnd_gap,
                          input int hold, input int busy_cyc);
    int   k;
    int   gap_left;
    int   held;
    bit   seen;
    logic iv_q, rdy_q, or_q;
    logic [7:0] res0;
    logic f0, ov0;
    @(negedge clk);
    start = 1'b1;
    bias  = b;
    out_ready = (hold == 0);
    k = 0; gap_left = 0; held = 0; seen = 0;
    res0 = '0; f0 = 1'b0; ov0 = 1'b0;
    got_to = 1'b1; got_unstable = 0; got_exit = 1'b0; got_lat = -1; got_busy_at = 1'b0;
    in_valid = 1'b1; x_in = vx[0]; w_in = vw[0];
    rdy_q = in_ready; iv_q = in_valid; or_q = out_ready;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      if (iv_q && rdy_q) begin
        k++;
        gap_left = rnd_gap ? int'($urandom_range(0, 2)) : gap;
      end
      if (seen && or_q) begin
        got_exit = !out_valid && !busy;
        got_res = res0; got_fire = f0; got_ov = ov0;
        got_to = 1'b0;
        break;
      end
      if (out_valid && !seen) begin
        seen = 1; got_lat = cyc;
        res0 = result; f0 = fire; ov0 = overflow;
      end else if (seen) begin
        if (!out_valid || result !== res0 || fire !== f0 || overflow !== ov0)
          got_unstable++;
      end
      if (seen) begin
        out_ready = (held >= hold);
        held++;
      end
      if (cyc == busy_cyc) got_busy_at = busy;
      start = (cyc == busy_cyc);
      bias  = start ? 8'd99 : 8'($urandom);
      if (k < N && gap_left == 0) begin
        in_valid = 1'b1; x_in = vx[k]; w_in = vw[k];
      end else begin
        if (gap_left > 0) gap_left--;
        in_valid = 1'b0; x_in = 8'($urandom); w_in = 8'($urandom);
      end
      rdy_q = in_ready; iv_q = in_valid; or_q = out_ready;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_tests++; if (result !== 8'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result); end
    n_tests++; if (fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %0b expected 0", fire); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    set_nominal();
    run_eval(8'd5, 0, 0, 0, 0);
    n_tests++; if (got_to !== 1'b0) begin n_fail++; $display("FAIL nominal_timeout: got %0b expected 0", got_to); end
    n_tests++; if (got_lat != N + 2) begin n_fail++; $display("FAIL nominal_latency: got %0d expected %0d", got_lat, N + 2); end
    n_tests++; if (got_res !== 8'd25) begin n_fail++; $display("FAIL nominal_result: got %0d expected 25", got_res); end
    n_tests++; if (got_fire !== 1'b0) begin n_fail++; $display("FAIL nominal_fire: got %0b expected 0", got_fire); end
    n_tests++; if (got_ov !== 1'b0) begin n_fail++; $display("FAIL nominal_overflow: got %0b expected 0", got_ov); end
    n_tests++; if (got_exit !== 1'b1) begin n_fail++; $display("FAIL nominal_exit: got %0b expected 1", got_exit); end
  endtask

  task automatic test_prod_sat();
    for (int i = 0; i < N; i++) begin vx[i] = 8'd0; vw[i] = 8'd0; end
    vx[0] = 8'd16; vw[0] = 8'd16;
    run_eval(8'd0, 0, 0, 0, 0);
    n_tests++; if (got_res !== 8'd255) begin n_fail++; $display("FAIL prod_sat_result: got %0d expected 255", got_res); end
    n_tests++; if (got_fire !== 1'b1) begin n_fail++; $display("FAIL prod_sat_fire: got %0b expected 1", got_fire); end
    n_tests++; if (got_ov !== 1'b1) begin n_fail++; $display("FAIL prod_sat_overflow: got %0b expected 1", got_ov); end
  endtask

  task automatic test_carry_sat();
    vx[0] = 8'd200; vx[1] = 8'd100; vx[2] = 8'd0; vx[3] = 8'd0;
    for (int i = 0; i < N; i++) vw[i] = 8'd1;
    run_eval(8'd0, 0, 0, 0, 0);
    n_tests++; if (got_res !== 8'd255) begin n_fail++; $display("FAIL carry_sat_result: got %0d expected 255", got_res); end
    n_tests++; if (got_ov !== 1'b1) begin n_fail++; $display("FAIL carry_sat_overflow: got %0b expected 1", got_ov); end
    repeat (2) @(negedge clk);
    n_tests++; if (result !== 8'd255 || overflow !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: got result=%0d ov=%0b busy=%0b expected 255/1/0", result, overflow, busy);
    end
    set_nominal();
    run_eval(8'd5, 0, 0, 0, 0);
    n_tests++; if (got_res !== 8'd25) begin n_fail++; $display("FAIL carry_rerun_result: got %0d expected 25", got_res); end
    n_tests++; if (got_ov !== 1'b0) begin n_fail++; $display("FAIL carry_rerun_overflow: got %0b expected 0", got_ov); end
  endtask

  task automatic test_in_backpressure();
    set_nominal();
    run_eval(8'd5, 2, 0, 0, 0);
    n_tests++; if (got_res !== 8'd25) begin n_fail++; $display("FAIL in_bp_result: got %0d expected 25", got_res); end
    n_tests++; if (got_lat != N + 2 + 2 * (N - 1)) begin
      n_fail++; $display("FAIL in_bp_latency: got %0d expected %0d", got_lat, N + 2 + 2 * (N - 1));
    end
  endtask

  task automatic test_out_backpressure();
    set_nominal();
    run_eval(8'd5, 0, 0, 3, 0);
    n_tests++; if (got_unstable != 0) begin n_fail++; $display("FAIL out_bp_stable: got %0d unstable cycles expected 0", got_unstable); end
    n_tests++; if (got_exit !== 1'b1) begin n_fail++; $display("FAIL out_bp_exit: got %0b expected 1", got_exit); end
    n_tests++; if (got_res !== 8'd25) begin n_fail++; $display("FAIL out_bp_result: got %0d expected 25", got_res); end
  endtask

  task automatic test_start_busy();
    set_nominal();
    run_eval(8'd5, 0, 0, 0, 2);
    n_tests++; if (got_busy_at !== 1'b1) begin n_fail++; $display("FAIL start_busy_busy: got %0b expected 1", got_busy_at); end
    n_tests++; if (got_res !== 8'd25) begin n_fail++; $display("FAIL start_busy_result: got %0d expected 25", got_res); end
  endtask

  task automatic test_reset_mid();
    int stray;
    // Leave non-zero outputs behind so the reset clear is observable.
    for (int i = 0; i < N; i++) begin vx[i] = 8'd0; vw[i] = 8'd0; end
    vx[0] = 8'd16; vw[0] = 8'd16;
    run_eval(8'd0, 0, 0, 0, 0);
    set_nominal();
    @(negedge clk); start = 1'b1; bias = 8'd5;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; x_in = vx[0]; w_in = vw[0];
    @(negedge clk); x_in = vx[1]; w_in = vw[1];
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got busy=%0b in_ready=%0b out_valid=%0b expected 0/0/0", busy, in_ready, out_valid);
    end
    n_tests++; if (result !== 8'd0 || fire !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_data: got result=%0d fire=%0b ov=%0b expected 0/0/0", result, fire, overflow);
    end
    stray = 0;
    repeat (8) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) stray++; end
    n_tests++; if (stray != 0) begin n_fail++; $display("FAIL mid_reset_no_result: got %0d active cycles expected 0", stray); end
    run_eval(8'd5, 0, 0, 0, 0);
    n_tests++; if (got_res !== 8'd25) begin n_fail++; $display("FAIL mid_reset_rerun: got %0d expected 25", got_res); end
  endtask

  task automatic test_random();
    logic [7:0] b, exp_r;
    logic exp_ov;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        vx[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 15));
        vw[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 15));
      end
      b = 8'($urandom);
      ref_model(b, exp_r, exp_ov);
      run_eval(b, 0, 1, int'($urandom_range(0, 2)), 0);
      n_tests++; if (got_to !== 1'b0 || got_res !== exp_r || got_fire !== (exp_r >= 8'd128) || got_ov !== exp_ov) begin
        n_fail++;
        $display("FAIL random_%0d: got to=%0b res=%0d fire=%0b ov=%0b expected to=0 res=%0d fire=%0b ov=%0b",
                 it, got_to, got_res, got_fire, got_ov, exp_r, (exp_r >= 8'd128), exp_ov);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
    x_in = '0; w_in = '0; out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_prod_sat();
    test_carry_sat();
    test_in_backpressure();
    test_out_backpressure();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_seq_ctrl.md
Name: neuron_seq_ctrl

Overview:
- Sequences one neuron evaluation over the shared 8-bit ripple datapath: streams N (input, weight) pairs, multiplies each, accumulates through a single 8-bit adder instance, adds a bias, then thresholds the sum.
- Sits between the input/weight source (valid/ready stream) and the downstream consumer (valid/ready result).
- Owns the adder operand muxing and saturation/overflow policy.

Parameters:
- N_INPUTS, 4, pairs accumulated per evaluation (1..255).
- THRESH, 8'd128, fire threshold; fire = (result >= THRESH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an evaluation when idle.
- bias  in  8  bias value, latched on the accepted start.
- busy  out  1  high from accepted start until result handshake completes.
- in_valid  in  1  x/w pair valid.
- in_ready  out  1  controller accepts a pair.
- x_in  in  8  unsigned input.
- w_in  in  8  unsigned weight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  8  saturated sum of products plus bias.
- fire  out  1  result >= THRESH.
- overflow  out  1  saturation occurred during this evaluation (sticky per evaluation).

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, busy=0, in_ready=0, out_valid=0, result=0, fire=0, overflow=0, count=0, acc=0, bias register=0. Reset wins over all other inputs, including mid-evaluation; partial accumulation is discarded and no result is emitted.
- FSM states: IDLE, ACCUM, BIAS, DONE.
- IDLE: start=1 -> latch bias, acc=0, count=0, overflow=0, go to ACCUM. Ignore start in any other state.
- ACCUM: in_ready=1. On each in_valid&&in_ready beat:
  - prod = x_in*w_in (16-bit); prod8 = 8'hFF if prod[15:8]!=0 (set overflow), else prod[7:0].
  - acc <= adder(acc, prod8); if adder carry=1, acc <= 8'hFF and set overflow.
  - count++.
  - On the beat where count reaches N_INPUTS-1, go to BIAS. in_ready deasserts the cycle after the last beat.
  - No beat when in_valid=0: acc and count hold.
- BIAS (exactly 1 cycle): acc <= adder(acc, bias_reg), saturating to 8'hFF on carry (set overflow); go to DONE.
- DONE:
  - out_valid=1; result=acc; fire=(acc>=THRESH).
  - All outputs are stable while out_valid=1 && out_ready=0.
  - out_valid&&out_ready -> IDLE; out_valid falls next cycle.
  - result, fire and overflow hold their last values in IDLE until the next accepted start clears overflow.
- Latency: with in_valid held high, the first beat is in the cycle after start, and out_valid rises N_INPUTS+2 cycles after the start cycle.
- Adder use: one 8-bit adder instance; operand B is muxed: prod8 in ACCUM, bias_reg in BIAS. No other adder.
- busy = (state != IDLE).

Decomposition:
- Package neuron_pkg:
  - state enum (IDLE, ACCUM, BIAS, DONE).
  - DATA_W=8.
  - SAT_MAX=8'hFF.
  - Saturating-product function.
- Instantiates the existing adder module (8-bit, sum+carry) as its only sub-module.
- Multiplier is inline (x_in*w_in).

Test Plan:
- Nominal: N=4, x={1,2,3,4}, w={2,2,2,2}, bias=5, in_valid held high, out_ready=1 -> result=25 (0x19), fire=0, overflow=0; out_valid rises 6 cycles after start.
- Product saturation: x=16, w=16, remaining pairs 0, bias=0 -> product clamps to 255; result=255, fire=1, overflow=1.
- Adder carry saturation: x={200,100,0,0}, w=1, bias=0 -> 200+100 carries; result=255, overflow=1. Then start a new run with the nominal data -> overflow=0, result=25.
- Backpressure:
  - in_valid low for 2 cycles between beats -> acc/count hold; final result unchanged (25).
  - out_ready low for 3 cycles in DONE -> result, fire and out_valid stable; exit to IDLE on the cycle after out_ready=1.
- Start while busy: pulse start during ACCUM with bias=99 -> ignored; result still uses the original bias=5 (25).
- Reset mid-operation: rst=1 after 2 beats -> next cycle all outputs are at reset values and state=IDLE. A fresh start with the nominal data -> result=25.
